// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: state encoding and
// digit width/limit.
package bcd_stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter. Carry is combinational so a whole chain
// of digits ripples within a single clock.
module bcd_digit
    import bcd_stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    assign carry = inc && (q == BCD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == BCD_MAX) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Tick-driven BCD stopwatch with start/pause/clear control. Counts only in
// RUN; either wraps at the all-nines count or parks in DONE.
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter bit STOP_AT_MAX = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic                        start_pause,
    input  logic                        clear,
    output logic [BCD_W*NUM_DIGITS-1:0] bcd,
    output logic                        running,
    output logic                        wrap,
    output logic                        done
);

    state_t                  state;
    state_t                  next_state;
    logic [NUM_DIGITS-1:0]   carry;
    logic [NUM_DIGITS-1:0]   inc;
    logic                    all_nine;
    logic                    count_en;

    always_comb begin
        all_nine = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*BCD_W +: BCD_W] != BCD_MAX) all_nine = 1'b0;
        end
    end

    // In stop mode the max count is held, so the increment is suppressed there.
    assign count_en = (state == RUN) && tick && !clear &&
                      !(STOP_AT_MAX && all_nine);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign inc[gi] = count_en;
            end else begin : g_upper
                assign inc[gi] = carry[gi-1];
            end

            bcd_digit u_digit (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc[gi]),
                .clr   (clear),
                .q     (bcd[gi*BCD_W +: BCD_W]),
                .carry (carry[gi])
            );
        end
    endgenerate

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_pause) next_state = RUN;
                RUN: begin
                    if (start_pause)
                        next_state = PAUSE;
                    else if (STOP_AT_MAX && tick && all_nine)
                        next_state = DONE;
                end
                PAUSE:   if (start_pause) next_state = RUN;
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN);
            done    <= (next_state == DONE);
            // Top carry can only fire on a real rollover (blocked in stop mode).
            wrap    <= carry[NUM_DIGITS-1];
        end
    end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Tick-driven BCD event counter/stopwatch that consumes the single-cycle `clk_en` enable produced by the clock_divider stage. It sits directly downstream of the divider and upstream of the 7-segment scan driver. It provides start/pause/clear control through a small FSM. Its BCD output feeds the display stage.

Parameters:
NUM_DIGITS, 4, number of cascaded BCD digits; count range 0 to 10^NUM_DIGITS-1.
STOP_AT_MAX, 0, 0 = wrap to zero at max; 1 = halt at max in DONE state.

Ports:
clk  input  1  system clock; every register in the block is clocked on its rising edge.
rst  input  1  asynchronous, active-high reset.
tick  input  1  count enable from clock_divider; one-cycle pulse; counted once per clk cycle it is high.
start_pause  input  1  one-cycle pulse (debounced upstream); toggles run/pause.
clear  input  1  one-cycle pulse; returns the block to IDLE with a zero count.
bcd  output  4*NUM_DIGITS  packed BCD count; digit 0 at bits [3:0]; registered.
running  output  1  high while state is RUN; registered.
wrap  output  1  one-cycle pulse on rollover from max to 0; registered.
done  output  1  high while state is DONE (STOP_AT_MAX=1 only); registered.

Behaviour:
- Reset (async, any time, including mid-count):
  - state = IDLE; bcd = 0; running = 0; wrap = 0; done = 0.
- FSM states and transitions (evaluated per clk edge):
  - IDLE: start_pause -> RUN.
  - RUN: start_pause -> PAUSE.
  - RUN: STOP_AT_MAX=1 and tick at max count -> DONE.
  - PAUSE: start_pause -> RUN.
  - DONE: start_pause is ignored; remains DONE until clear.
  - Any state: clear -> IDLE.
- Counting:
  - Occurs only when the current (pre-edge) state is RUN and tick=1.
  - The new bcd value is visible on the edge that samples tick. Latency is 1 clk.
- BCD arithmetic:
  - Digit i increments when all lower digits equal 9 (ripple carry within one cycle).
  - A digit at 9 with carry-in becomes 0 and propagates carry.
  - No digit ever holds a value above 9.
- Max count (all digits 9) plus tick:
  - STOP_AT_MAX=0: bcd -> 0, wrap=1 for exactly one cycle, state stays RUN.
  - STOP_AT_MAX=1: bcd holds max, state -> DONE, done=1, wrap stays 0.
- Simultaneous events:
  - clear has top priority. clear+tick or clear+start_pause gives IDLE with bcd=0, and the tick is discarded.
  - RUN with start_pause+tick: the tick is counted and state -> PAUSE.
  - PAUSE or IDLE with start_pause+tick: the tick is not counted and state -> RUN.
- Tick handling: a tick held high for N cycles in RUN advances the count by N. No edge detection is done on tick.
- Output timing: running and done are registered decodes of the next state, so they change on the same edge as the state.
- wrap defaults to 0 in every cycle in which no rollover occurs.

Decomposition:
- Shared package:
  - State encoding constants IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - BCD_W=4.
  - BCD_MAX=4'd9.
- Sub-module bcd_digit:
  - Ports: clk, rst, inc, clr → q[3:0], carry.
  - carry is combinational and equals inc && q==9.
  - Instantiated NUM_DIGITS times in a generate loop.
  - Digit i's inc input is driven by the carry from digit i-1.
  - Digit 0's inc is driven by count_en; inc should not be described as a chain of ANDs of the lower carries, because carry already includes inc.
- Top-level FSM and wrap/done logic stay in bcd_stopwatch.

Test Plan:
- Reset then idle: rst pulse, 20 ticks, no start_pause -> bcd=0x0000, running=0, wrap=0, done=0.
- Basic count: start_pause, then 12 ticks -> bcd=0x0012, running=1; the first increment appears one clk after the first tick.
- Pause/resume: from 0x0012, start_pause, 5 ticks, start_pause, 3 ticks -> bcd=0x0015; start_pause+tick in the same cycle while in RUN -> tick counted, state PAUSE.
- Digit carry: count to 0x0099, then 1 tick -> 0x0100. Count to 0x0999, then 1 tick -> 0x1000. Any nibble above 9 at any time is a failure.
- Rollover: STOP_AT_MAX=0, at 0x9999 apply 1 tick -> 0x0000, wrap high for exactly 1 cycle, running=1. STOP_AT_MAX=1, same stimulus -> bcd stays 0x9999, done=1, a subsequent start_pause is ignored, then clear -> 0x0000 and IDLE.
- Priority and async reset: clear+tick+start_pause in RUN -> IDLE, bcd=0. Assert rst between clk edges mid-count at 0x0347 -> all outputs 0 immediately, without waiting for a clk edge.
